// File: rtl/fetch_unit.sv
// IF stage with PC ownership and the IF/ID pipeline register; synchronous-read imem.
// Optional FETCH_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush_IFID,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_F,
   output logic [31:0] PC_ID,
   output logic [31:0] PC4_ID,
   output logic [31:0] Instr_ID,
   output logic        valid_ID
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic [31:0] pc4_id_q, pc4_id_d;
   logic [31:0] instr_id_q, instr_id_d;
   logic        valid_id_q, valid_id_d;

   logic [31:0] pc_plus4;
   logic [31:0] branch_pc;
   logic        load_bubble;
   logic        unused_target_bits;

   assign pc_plus4           = pc_f_q + 32'd4;
   assign branch_pc          = {BranchTarget[31:2], 2'b00};
   assign unused_target_bits = ^BranchTarget[1:0];

   // A stalled branch in ID is still unresolved, so stall masks redirect and flush.
   assign load_bubble = !rst && !stall && (BranchTaken || flush_IFID);

   always_comb begin
      imem_addr  = pc_plus4;
      pc_f_d     = pc_f_q;
      pc_id_d    = pc_id_q;
      pc4_id_d   = pc4_id_q;
      instr_id_d = instr_id_q;
      valid_id_d = valid_id_q;
      if (rst) begin
         imem_addr = RESET_PC;
      end else if (stall) begin
         imem_addr = pc_f_q;
      end else if (BranchTaken) begin
         imem_addr  = branch_pc;
         pc_f_d     = branch_pc;
         pc_id_d    = 32'd0;
         pc4_id_d   = 32'd0;
         instr_id_d = NOP_INSTR;
         valid_id_d = 1'b0;
      end else if (flush_IFID) begin
         pc_f_d     = pc_plus4;
         pc_id_d    = 32'd0;
         pc4_id_d   = 32'd0;
         instr_id_d = NOP_INSTR;
         valid_id_d = 1'b0;
      end else begin
         pc_f_d     = pc_plus4;
         pc_id_d    = pc_f_q;
         pc4_id_d   = pc_plus4;
         instr_id_d = imem_rdata;
         valid_id_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_f_q     <= RESET_PC;
         pc_id_q    <= 32'd0;
         pc4_id_q   <= 32'd0;
         instr_id_q <= NOP_INSTR;
         valid_id_q <= 1'b0;
      end else begin
         pc_f_q     <= pc_f_d;
         pc_id_q    <= pc_id_d;
         pc4_id_q   <= pc4_id_d;
         instr_id_q <= instr_id_d;
         valid_id_q <= valid_id_d;
      end
   end

   assign PC_F     = pc_f_q;
   assign PC_ID    = pc_id_q;
   assign PC4_ID   = pc4_id_q;
   assign Instr_ID = instr_id_q;
   assign valid_ID = valid_id_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!rst && stall) stall_cnt_d = stall_cnt_q + 32'd1;
      if (load_bubble)   flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_load_bubble;
   assign unused_load_bubble = load_bubble;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the fetch/IF-ID rules.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush_IFID = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = 32'd0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] PC_F, PC_ID, PC4_ID, Instr_ID;
   logic        valid_ID;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   logic [31:0] m_pcf, m_pcid, m_pc4, m_instr;
   logic        m_valid;
   logic [31:0] m_stall_cnt, m_flush_cnt;

   fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush_IFID(flush_IFID),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .PC_F(PC_F), .PC_ID(PC_ID), .PC4_ID(PC4_ID), .Instr_ID(Instr_ID),
      .valid_ID(valid_ID)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a pure function of address.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   always @(posedge clk) imem_rdata <= mem_f(imem_addr);

   function automatic logic [31:0] exp_addr();
      if (rst)              return RST_PC;
      else if (stall)       return m_pcf;
      else if (BranchTaken) return {BranchTarget[31:2], 2'b00};
      else                  return m_pcf + 32'd4;
   endfunction

   task automatic drive(input logic r, input logic s, input logic b,
                        input logic [31:0] t, input logic f);
      @(negedge clk);
      rst = r; stall = s; BranchTaken = b; BranchTarget = t; flush_IFID = f;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_pcf = RST_PC; m_pcid = 0; m_pc4 = 0; m_instr = NOP; m_valid = 0;
         m_stall_cnt = 0; m_flush_cnt = 0;
      end else if (stall) begin
         m_stall_cnt = m_stall_cnt + 1;
      end else if (BranchTaken || flush_IFID) begin
         m_pcf = BranchTaken ? {BranchTarget[31:2], 2'b00} : m_pcf + 32'd4;
         m_pcid = 0; m_pc4 = 0; m_instr = NOP; m_valid = 0;
         m_flush_cnt = m_flush_cnt + 1;
      end else begin
         m_pcid = m_pcf; m_pc4 = m_pcf + 32'd4; m_instr = mem_f(m_pcf); m_valid = 1;
         m_pcf = m_pcf + 32'd4;
      end
      #1;
      cyc++;
      $display("cyc %0d rst=%b stall=%b br=%b fl=%b PC_F=%h PC_ID=%h Instr=%h valid=%b",
               cyc, rst, stall, BranchTaken, flush_IFID, PC_F, PC_ID, Instr_ID, valid_ID);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 0);
         checks++;
         if (imem_addr !== RST_PC) begin
            errors++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, RST_PC);
         end
         tick();
      end
      drive(0, 0, 0, 0, 0);
      checks++;
      if (PC_F !== RST_PC || valid_ID !== 1'b0 || PC_ID !== 32'd0 || PC4_ID !== 32'd0 || Instr_ID !== NOP) begin
         errors++;
         $display("FAIL reset_state: got PC_F=%h PC_ID=%h PC4=%h Instr=%h v=%b want %h 0 0 %h 0",
                  PC_F, PC_ID, PC4_ID, Instr_ID, valid_ID, RST_PC, NOP);
      end
      tick();
      checks++;
      if (PC_ID !== RST_PC || Instr_ID !== mem_f(RST_PC) || valid_ID !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_valid: got PC_ID=%h Instr=%h v=%b want %h %h 1",
                  PC_ID, Instr_ID, valid_ID, RST_PC, mem_f(RST_PC));
      end
   endtask

   task automatic test_straight();
      for (int i = 1; i < 8; i++) begin
         drive(0, 0, 0, 0, 0);
         tick();
         checks++;
         if (PC_ID !== RST_PC + 32'(4 * i) || PC4_ID !== RST_PC + 32'(4 * i + 4) ||
             valid_ID !== 1'b1 || Instr_ID !== mem_f(RST_PC + 32'(4 * i))) begin
            errors++;
            $display("FAIL straight_%0d: got PC_ID=%h PC4=%h Instr=%h v=%b want PC_ID=%h",
                     i, PC_ID, PC4_ID, Instr_ID, valid_ID, RST_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_stall();
      drive(1, 0, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0); tick(); end
      // PC_ID = 0x108 now
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 0, 0);
         checks++;
         if (imem_addr !== 32'h10C || PC_F !== 32'h10C) begin
            errors++; $display("FAIL stall_addr_%0d: got addr=%h PC_F=%h want 10c", i, imem_addr, PC_F);
         end
         tick();
         checks++;
         if (PC_ID !== 32'h108 || Instr_ID !== mem_f(32'h108) || valid_ID !== 1'b1) begin
            errors++; $display("FAIL stall_hold_%0d: got PC_ID=%h Instr=%h want 108", i, PC_ID, Instr_ID);
         end
      end
      drive(0, 0, 0, 0, 0); tick();
      checks++;
      if (PC_ID !== 32'h10C || Instr_ID !== mem_f(32'h10C) || valid_ID !== 1'b1) begin
         errors++; $display("FAIL stall_release: got PC_ID=%h Instr=%h want 10c", PC_ID, Instr_ID);
      end
   endtask

   task automatic test_redirect();
      drive(0, 0, 0, 0, 0); tick();   // PC_ID = 0x110
      drive(0, 0, 1, 32'h203, 0);
      checks++;
      if (imem_addr !== 32'h200) begin
         errors++; $display("FAIL redirect_addr: got %h want 200", imem_addr);
      end
      tick();
      checks++;
      if (valid_ID !== 1'b0 || Instr_ID !== NOP || PC_F !== 32'h200) begin
         errors++; $display("FAIL redirect_bubble: got v=%b Instr=%h PC_F=%h want 0 %h 200", valid_ID, Instr_ID, PC_F, NOP);
      end
      drive(0, 0, 0, 0, 0); tick();
      checks++;
      if (PC_ID !== 32'h200 || valid_ID !== 1'b1 || Instr_ID !== mem_f(32'h200)) begin
         errors++; $display("FAIL redirect_target: got PC_ID=%h v=%b want 200 1", PC_ID, valid_ID);
      end
   endtask

   task automatic test_flush();
      logic [31:0] pcf0;
      pcf0 = PC_F;
      drive(0, 0, 0, 0, 1);
      checks++;
      if (imem_addr !== pcf0 + 32'd4) begin
         errors++; $display("FAIL flush_addr: got %h want %h", imem_addr, pcf0 + 32'd4);
      end
      tick();
      checks++;
      if (valid_ID !== 1'b0 || Instr_ID !== NOP || PC_ID !== 32'd0 || PC_F !== pcf0 + 32'd4) begin
         errors++; $display("FAIL flush_bubble: got v=%b Instr=%h PC_ID=%h PC_F=%h", valid_ID, Instr_ID, PC_ID, PC_F);
      end
      drive(0, 0, 0, 0, 0); tick();
      checks++;
      if (PC_ID !== pcf0 + 32'd4 || valid_ID !== 1'b1) begin
         errors++; $display("FAIL flush_skip: got PC_ID=%h want %h", PC_ID, pcf0 + 32'd4);
      end
   endtask

   task automatic test_collision();
      logic [31:0] pcf0, pcid0;
      pcf0 = PC_F; pcid0 = PC_ID;
      drive(0, 1, 1, 32'h0000_4000, 1);
      checks++;
      if (imem_addr !== pcf0) begin
         errors++; $display("FAIL collision_addr: got %h want %h", imem_addr, pcf0);
      end
      tick();
      checks++;
      if (PC_F !== pcf0 || PC_ID !== pcid0 || valid_ID !== 1'b1) begin
         errors++; $display("FAIL collision_hold: got PC_F=%h PC_ID=%h v=%b want %h %h 1", PC_F, PC_ID, valid_ID, pcf0, pcid0);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
         errors++; $display("FAIL collision_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
      end
`endif
   endtask

   task automatic test_wrap_reset();
      drive(0, 0, 1, 32'hFFFF_FFFE, 0); tick();
      drive(0, 0, 0, 0, 0);
      checks++;
      if (PC_F !== 32'hFFFF_FFFC || imem_addr !== 32'd0) begin
         errors++; $display("FAIL wrap_addr: got PC_F=%h addr=%h want fffffffc 0", PC_F, imem_addr);
      end
      tick();
      checks++;
      if (PC_F !== 32'd0 || PC_ID !== 32'hFFFF_FFFC || PC4_ID !== 32'd0) begin
         errors++; $display("FAIL wrap_state: got PC_F=%h PC_ID=%h PC4=%h", PC_F, PC_ID, PC4_ID);
      end
      drive(0, 1, 0, 0, 0); tick();
      drive(1, 1, 1, 32'h800, 1);
      checks++;
      if (imem_addr !== RST_PC) begin
         errors++; $display("FAIL rst_stall_addr: got %h want %h", imem_addr, RST_PC);
      end
      tick();
      checks++;
      if (PC_F !== RST_PC || valid_ID !== 1'b0 || Instr_ID !== NOP) begin
         errors++; $display("FAIL rst_stall_state: got PC_F=%h v=%b Instr=%h", PC_F, valid_ID, Instr_ID);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 10,
               $urandom, $urandom_range(99) < 10);
         checks++;
         if (imem_addr !== exp_addr()) begin
            errors++; $display("FAIL rand_addr_%0d: got %h want %h", i, imem_addr, exp_addr());
         end
         tick();
         checks++;
         if (PC_F !== m_pcf || PC_ID !== m_pcid || PC4_ID !== m_pc4 ||
             Instr_ID !== m_instr || valid_ID !== m_valid) begin
            errors++;
            $display("FAIL rand_state_%0d: got %h %h %h %h %b want %h %h %h %h %b", i,
                     PC_F, PC_ID, PC4_ID, Instr_ID, valid_ID, m_pcf, m_pcid, m_pc4, m_instr, m_valid);
         end
`ifdef FETCH_PERF_CNT_EN
         checks++;
         if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
            errors++; $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
         end
`endif
      end
   endtask

   initial begin
      m_pcf = 0; m_pcid = 0; m_pc4 = 0; m_instr = NOP; m_valid = 0;
      m_stall_cnt = 0; m_flush_cnt = 0;
      test_reset();
      test_straight();
      test_stall();
      test_redirect();
      test_flush();
      test_collision();
      test_wrap_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
